// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline-register stages of the 5-stage MIPS core.
package pipeline_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between fetch and decode: write-enable, bubble injection, async reset.
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t entry_q;
    ifid_t entry_d;

    // NOTE: assigning the held value first makes every path drive entry_d, so no latch is inferred.
    always_comb begin
        entry_d = entry_q;
        if (bubble) begin
            // A bubble keeps pc4 so the hazard unit still sees the last sequential address.
            entry_d.instr = NOP_INSTR;
            entry_d.valid = 1'b0;
        end else if (we) begin
            entry_d = d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q.instr <= NOP_INSTR;
            entry_q.pc4   <= '0;
            entry_q.valid <= 1'b0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, imem handshake with a one-word
// skid buffer for stalls, and discard of an in-flight fetch after a late redirect.
module if_stage
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid
);

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       skid_q, skid_d;
    logic [ADDR_W-1:0] pending_q, pending_d;

    logic              stall;
    logic              take;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ifid_we;
    logic              ifid_bubble;
    ifid_t             ifid_in;
    ifid_t             ifid_q;

    assign stall    = ~pc_write | ~ifid_write;
    assign take     = redirect & ifid_q.valid & ~stall;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        pending_d     = pending_q;
        imem_req      = 1'b1;
        ifid_we       = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_in.instr = imem_rdata;
        ifid_in.pc4   = XLEN'(pc_plus4);
        ifid_in.valid = 1'b1;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (take) begin
                        ifid_bubble = 1'b1;
                        pc_d        = redirect_pc;
                    end else if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        ifid_we = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (take) begin
                    // The request to the old PC must complete before the target can be fetched.
                    ifid_bubble = 1'b1;
                    pending_d   = redirect_pc;
                    state_d     = DISCARD;
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            HOLD: begin
                imem_req      = 1'b0;
                ifid_in.instr = skid_q;
                if (take) begin
                    ifid_bubble = 1'b1;
                    pc_d        = redirect_pc;
                    state_d     = FETCH;
                end else if (!stall) begin
                    ifid_we = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end

            DISCARD: begin
                ifid_bubble = ~stall;
                if (imem_ready) begin
                    pc_d    = pending_q;
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            skid_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            skid_q    <= skid_d;
            pending_q <= pending_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .we    (ifid_we),
        .bubble(ifid_bubble),
        .d     (ifid_in),
        .q     (ifid_q)
    );

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc4   = ifid_q.pc4[ADDR_W-1:0];
    assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a transaction-level fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Fetch model in terms of "a word is parked", "a fetch is doomed" and the IF/ID contents.
    typedef struct packed {
        logic [31:0] pc;
        logic        parked;
        logic [31:0] parked_word;
        logic        doomed;
        logic [31:0] doomed_target;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, logic pw, logic iw, logic rd,
                                          logic [31:0] rpc, logic rdy, logic [31:0] rdat);
        model_t n;
        logic   st, tk, got, bub;
        n   = c;
        st  = !pw || !iw;
        tk  = rd && c.valid && !st;
        got = !c.parked && rdy;
        bub = 1'b0;
        if (c.doomed) begin
            if (got) begin
                n.pc     = c.doomed_target;
                n.doomed = 1'b0;
            end
            bub = !st;
        end else if (c.parked) begin
            if (tk) begin
                bub      = 1'b1;
                n.pc     = rpc;
                n.parked = 1'b0;
            end else if (!st) begin
                n.instr  = c.parked_word;
                n.pc4    = c.pc + 32'd4;
                n.valid  = 1'b1;
                n.pc     = c.pc + 32'd4;
                n.parked = 1'b0;
            end
        end else if (got) begin
            if (tk) begin
                bub  = 1'b1;
                n.pc = rpc;
            end else if (st) begin
                n.parked      = 1'b1;
                n.parked_word = rdat;
            end else begin
                n.instr = rdat;
                n.pc4   = c.pc + 32'd4;
                n.valid = 1'b1;
                n.pc    = c.pc + 32'd4;
            end
        end else if (tk) begin
            bub             = 1'b1;
            n.doomed        = 1'b1;
            n.doomed_target = rpc;
        end else begin
            bub = !st;
        end
        if (bub) begin
            n.instr = 32'h0;
            n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, pc_write, ifid_write, redirect, redirect_pc, imem_ready, imem_rdata);
    end

    always @(negedge clk) begin
        check("imem_req",   {31'b0, imem_req},   {31'b0, !m.parked});
        check("imem_addr",  imem_addr,           m.pc);
        check("ifid_instr", ifid_instr,          m.instr);
        check("ifid_pc4",   ifid_pc4,            m.pc4);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m.valid});
    end

    function automatic logic [31:0] tag(input logic [31:0] a);
        return 32'hA500_0000 | {8'h00, a[23:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic pw, input logic iw, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] rdat);
        #2;
        pc_write    = pw;
        ifid_write  = iw;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rdat;
    endtask

    task automatic expect_out(input string name, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        check({name, ".req"},   {31'b0, imem_req},   {31'b0, req});
        check({name, ".addr"},  imem_addr,           addr);
        check({name, ".instr"}, ifid_instr,          instr);
        check({name, ".pc4"},   ifid_pc4,            pc4);
        check({name, ".valid"}, {31'b0, ifid_valid}, {31'b0, valid});
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        expect_out("reset", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(1, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Back-to-back fetches.
        drive(1, 1, 0, 0, 1, tag(32'h0)); tick();
        expect_out("seq0", 1'b1, 32'h4, tag(32'h0), 32'h4, 1'b1);
        drive(1, 1, 0, 0, 1, tag(32'h4)); tick();
        expect_out("seq1", 1'b1, 32'h8, tag(32'h4), 32'h8, 1'b1);
        drive(1, 1, 0, 0, 1, tag(32'h8)); tick();
        expect_out("seq2", 1'b1, 32'hC, tag(32'h8), 32'hC, 1'b1);

        // Stall with data arriving in the first stall cycle, then release.
        drive(0, 0, 0, 0, 1, tag(32'hC)); tick();
        expect_out("stall0", 1'b0, 32'hC, tag(32'h8), 32'hC, 1'b1);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF); tick();
        expect_out("stall1", 1'b0, 32'hC, tag(32'h8), 32'hC, 1'b1);
        drive(0, 0, 1, 32'h500, 0, 0); tick();
        expect_out("stall_redir", 1'b0, 32'hC, tag(32'h8), 32'hC, 1'b1);
        drive(1, 1, 0, 0, 0, 0); tick();
        expect_out("unstall", 1'b1, 32'h10, tag(32'hC), 32'h10, 1'b1);

        // Redirect with data ready: the returned word is dropped.
        drive(1, 1, 1, 32'h40, 1, tag(32'h10)); tick();
        expect_out("redir", 1'b1, 32'h40, 32'h0, 32'h10, 1'b0);
        drive(1, 1, 0, 0, 1, tag(32'h40)); tick();
        expect_out("redir_tgt", 1'b1, 32'h44, tag(32'h40), 32'h44, 1'b1);

        // Redirect while the fetch is still outstanding.
        drive(1, 1, 1, 32'h80, 0, 0); tick();
        expect_out("late0", 1'b1, 32'h44, 32'h0, 32'h44, 1'b0);
        drive(1, 1, 0, 0, 0, 0); tick();
        expect_out("late1", 1'b1, 32'h44, 32'h0, 32'h44, 1'b0);
        drive(1, 1, 0, 0, 1, tag(32'h44)); tick();
        expect_out("late_drop", 1'b1, 32'h80, 32'h0, 32'h44, 1'b0);
        drive(1, 1, 0, 0, 1, tag(32'h80)); tick();
        expect_out("late_tgt", 1'b1, 32'h84, tag(32'h80), 32'h84, 1'b1);

        // Redirect ignored under stall, and ignored with ifid_valid=0.
        drive(0, 1, 1, 32'h200, 0, 0); tick();
        expect_out("ign_stall", 1'b1, 32'h84, tag(32'h80), 32'h84, 1'b1);
        drive(1, 1, 0, 0, 0, 0); tick();
        expect_out("consumed", 1'b1, 32'h84, 32'h0, 32'h84, 1'b0);
        drive(1, 1, 1, 32'h300, 1, tag(32'h84)); tick();
        expect_out("ign_invalid", 1'b1, 32'h88, tag(32'h84), 32'h88, 1'b1);

        // Asynchronous reset in the middle of an outstanding request.
        drive(1, 1, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 expect_out("rst_req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Asynchronous reset while a word is parked.
        drive(1, 1, 0, 0, 1, tag(32'h0)); tick();
        expect_out("pre_hold", 1'b1, 32'h4, tag(32'h0), 32'h4, 1'b1);
        drive(0, 0, 0, 0, 1, tag(32'h4)); tick();
        expect_out("hold", 1'b0, 32'h4, tag(32'h0), 32'h4, 1'b1);
        #2 rst = 1'b1;
        #1 expect_out("rst_hold", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // PC wrap-around.
        drive(1, 1, 0, 0, 1, tag(32'h0)); tick();
        drive(1, 1, 1, 32'hFFFF_FFFC, 1, tag(32'h4)); tick();
        expect_out("to_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h4, 1'b0);
        drive(1, 1, 0, 0, 1, tag(32'hFFFF_FFFC)); tick();
        expect_out("wrap", 1'b1, 32'h0, tag(32'hFFFF_FFFC), 32'h0, 1'b1);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                  $urandom(), $urandom_range(1), $urandom());
            rst = ($urandom_range(149) == 0);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the hazard unit's pc_write and IF/ID write-enable stall controls, and the ID-stage branch/jump redirect.
- Produces the IF/ID instruction, PC+4 and valid bit read by the ID stage and the hazard unit.

Parameters:
- ADDR_W, 32: PC and memory address width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- NOP_INSTR, 32'h0000_0000: instruction word loaded into IF/ID on a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_write  in  1  hazard unit: 0 = hold PC.
- ifid_write  in  1  hazard unit: 0 = hold IF/ID.
- redirect  in  1  ID stage: branch taken or jump.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals the PC.
- imem_ready  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  ADDR_W  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Definitions: stall = ~pc_write | ~ifid_write. take = redirect & ifid_valid & ~stall. A redirect is ignored when stalled or when ifid_valid=0.
- Reset (async, any state, mid-request included):
  - pc=RESET_PC, state=FETCH.
  - ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, skid buffer=0, pending_pc=0.
  - imem_req=1 and imem_addr=RESET_PC while in reset and after release.
- imem_addr is held stable while imem_req=1 until imem_ready. imem_ready is ignored when imem_req=0. Fetch latency is one or more cycles.
- FSM states FETCH, HOLD, DISCARD. imem_req=1 in FETCH and DISCARD, 0 in HOLD.
- FETCH with imem_ready=1:
  - take: IF/ID <= bubble (NOP_INSTR, pc4 unchanged, valid=0); pc <= redirect_pc; stay in FETCH; rdata dropped.
  - stall: IF/ID and pc held; skid <= rdata; go to HOLD.
  - otherwise: IF/ID <= {rdata, pc+4, 1}; pc <= pc+4; stay in FETCH.
- FETCH with imem_ready=0:
  - take: IF/ID <= bubble; pending_pc <= redirect_pc; go to DISCARD.
  - ~stall: IF/ID <= bubble, because ID has consumed its instruction.
  - stall: hold everything.
- HOLD:
  - stall: hold.
  - take: bubble; pc <= redirect_pc; skid dropped; go to FETCH.
  - otherwise: IF/ID <= {skid, pc+4, 1}; pc <= pc+4; go to FETCH.
- DISCARD:
  - Request to the old pc continues.
  - On imem_ready: data dropped; pc <= pending_pc; go to FETCH.
  - IF/ID takes a bubble on any ~stall cycle.
  - take cannot occur here because ifid_valid=0.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag. PC bits [1:0] are passed through unchecked.
- Priority: reset > take > stall > normal advance.
- One IF/ID update per cycle maximum. A bubble never advances the PC.

Decomposition:
- Shared package pipeline_pkg:
  - if_state_t enum {FETCH, HOLD, DISCARD}.
  - NOP constant.
  - ifid_t struct {instr, pc4, valid}; the ID/EX register reuses it.
- One sub-module: ifid_reg, the IF/ID register with write-enable and bubble input and async reset. The FSM and PC logic stay in if_stage.

Test Plan:
- Reset, then imem_ready=1 every cycle with rdata=pc-tagged words, no stall -> imem_addr 0,4,8,…; ifid_instr follows one cycle after each address; ifid_pc4=4,8,12; ifid_valid=1 from the first ready.
- pc_write=ifid_write=0 for 3 cycles with a ready arriving in the first stall cycle -> state HOLD; imem_req=0; IF/ID and PC frozen. On release, IF/ID = buffered word with correct pc4; next imem_addr = pc+4.
- redirect=1, redirect_pc=0x40 with ifid_valid=1, no stall, ready=1 -> next cycle ifid_valid=0 and ifid_instr=NOP; imem_addr=0x40; the dropped word never reaches IF/ID.
- redirect to 0x80 while the current fetch is still pending (ready low 2 cycles) -> imem_addr unchanged until ready; that data is discarded; imem_addr=0x80 on the following cycle; IF/ID shows bubbles meanwhile.
- redirect=1 during a stall -> ignored; PC and IF/ID unchanged. redirect with ifid_valid=0 -> ignored.
- rst asserted asynchronously mid-request and in HOLD -> all outputs go to reset values immediately; after release imem_addr=RESET_PC and imem_req=1; pc wraps 0xFFFF_FFFC -> 0x0000_0000.
